// File: rtl/cpc_bus_pkg.sv
// Shared definitions for the CPC backplane buffer controller: FSM encoding,
// transceiver direction values and a width helper for the reset-stretch counter.
package cpc_bus_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_TURN  = 2'd1;
  localparam logic [1:0] ST_WRITE = 2'd2;
  localparam logic [1:0] ST_READ  = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE  = ST_IDLE,
    S_TURN  = ST_TURN,
    S_WRITE = ST_WRITE,
    S_READ  = ST_READ
  } state_e;

  localparam logic DIR_TO_BP  = 1'b1;
  localparam logic DIR_TO_CPC = 1'b0;

  // Bits needed to hold (value - 1); never less than one.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned width;
    width = 1;
    while ((64'd1 << width) < 64'(value)) width++;
    return width;
  endfunction

endpackage

// File: rtl/cpc_reset_stretch.sv
// Backplane reset generator: synchronises the reset button and holds
// busreset_b low for RST_CYCLES clocks after reset or button release.
module cpc_reset_stretch
  import cpc_bus_pkg::*;
#(
  parameter int unsigned RST_CYCLES  = 16'd4000,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic rstbtn_b,
  output logic busreset_b,
  output logic stretch_active
);

  localparam int unsigned          CNT_W  = clog2(RST_CYCLES);
  localparam logic [CNT_W-1:0]     RELOAD = CNT_W'(RST_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CNT_W-1:0]       count_q;
  logic                   btn_released;

  assign btn_released = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: synchroniser flops reset to the button's idle level (1) so a
      // reset release never looks like a fresh press.
      sync_q     <= '1;
      count_q    <= RELOAD;
      busreset_b <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here so every flop samples the
      // pre-edge values; blocking would collapse the synchroniser chain.
      sync_q <= {sync_q[SYNC_STAGES-2:0], rstbtn_b};
      if (!btn_released) begin
        count_q <= RELOAD;
      end else if (count_q != '0) begin
        count_q <= count_q - CNT_W'(1);
      end
      busreset_b <= btn_released && (count_q == '0);
    end
  end

  assign stretch_active = !busreset_b;

endmodule

// File: rtl/cpc_bus_buffer_ctrl.sv
// Buffer control for the CPC-to-backplane interface: decodes Z80 cycles into
// transceiver enable/direction with break-before-make turnaround.
module cpc_bus_buffer_ctrl
  import cpc_bus_pkg::*;
#(
  parameter int unsigned RST_CYCLES  = 16'd4000,
  parameter int unsigned SYNC_STAGES = 2,
  parameter bit          INTACK_EN   = 1'b1
) (
  input  logic CLK,
  input  logic RESET_B,
  input  logic RSTBTN_B,
  input  logic MREQ_B,
  input  logic IOREQ_B,
  input  logic RD_B,
  input  logic WR_B,
  input  logic M1_B,
  input  logic RFSH_B,
  input  logic A10,
  input  logic ROMDIS,
  input  logic RAMDIS,
  input  logic BUSACK_B,
  output logic DBUF_OE_B,
  output logic DBUF_DIR,
  output logic ABUF_OE_B,
  output logic BUSRESET_B
);

  logic stretch_active;
  logic busreset_b;

  cpc_reset_stretch #(
    .RST_CYCLES (RST_CYCLES),
    .SYNC_STAGES(SYNC_STAGES)
  ) u_reset_stretch (
    .clk           (CLK),
    .rst_n         (RESET_B),
    .rstbtn_b      (RSTBTN_B),
    .busreset_b    (busreset_b),
    .stretch_active(stretch_active)
  );

  // Request decode. Refresh cycles never transfer; a write overrides a read.
  logic intack, wreq, rreq_raw, rreq, bus_grant;

  always_comb begin
    intack    = INTACK_EN && !M1_B && !IOREQ_B;
    wreq      = RFSH_B && !WR_B && (!MREQ_B || !IOREQ_B);
    rreq_raw  = RFSH_B && ((!RD_B && !MREQ_B && (ROMDIS || RAMDIS)) ||
                           (!RD_B && !IOREQ_B && M1_B && !A10) ||
                           intack);
    rreq      = rreq_raw && !wreq;
    bus_grant = !BUSACK_B;
  end

  state_e state_q, state_d;
  logic   oe_b_q, oe_b_d;
  logic   dir_q, dir_d;
  logic   abuf_oe_b_q;

  // Direction only moves on entry to TURN, where the enable is already off.
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves a
    // variable unassigned, which would infer a latch.
    state_d = state_q;
    oe_b_d  = 1'b1;
    dir_d   = dir_q;
    if (stretch_active || bus_grant) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (wreq) begin
            if (dir_q == DIR_TO_BP) begin
              state_d = S_WRITE;
              oe_b_d  = 1'b0;
            end else begin
              state_d = S_TURN;
              dir_d   = DIR_TO_BP;
            end
          end else if (rreq) begin
            if (dir_q == DIR_TO_CPC) begin
              state_d = S_READ;
              oe_b_d  = 1'b0;
            end else begin
              state_d = S_TURN;
              dir_d   = DIR_TO_CPC;
            end
          end
        end
        S_TURN: begin
          if (wreq && dir_q == DIR_TO_BP) begin
            state_d = S_WRITE;
            oe_b_d  = 1'b0;
          end else if (rreq && dir_q == DIR_TO_CPC) begin
            state_d = S_READ;
            oe_b_d  = 1'b0;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_WRITE: begin
          if (wreq) oe_b_d  = 1'b0;
          else      state_d = S_IDLE;
        end
        S_READ: begin
          if (rreq) oe_b_d  = 1'b0;
          else      state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RESET_B) begin
    if (!RESET_B) begin
      state_q     <= S_IDLE;
      oe_b_q      <= 1'b1;
      dir_q       <= DIR_TO_BP;
      abuf_oe_b_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      oe_b_q      <= oe_b_d;
      dir_q       <= dir_d;
      abuf_oe_b_q <= bus_grant;
    end
  end

  assign DBUF_OE_B  = oe_b_q;
  assign DBUF_DIR   = dir_q;
  assign ABUF_OE_B  = abuf_oe_b_q;
  assign BUSRESET_B = busreset_b;

endmodule
